// File: rtl/cpu_pkg.sv
// Shared CPU register-file constants and the write-request record used by the
// writeback queue and its bench.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 3;
  localparam int REG_COUNT = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Youngest-first forwarding match over the queue entries plus the output register.
// Only built when WBQ_BYPASS_EN is defined; the queue has no use for it otherwise.
`ifdef WBQ_BYPASS_EN
module wbq_fwd_match
  import cpu_pkg::*;
#(
  parameter int MATCH_DATA_W = DATA_W,
  parameter int MATCH_ADDR_W = ADDR_W,
  parameter int N            = 4
) (
  input  logic [MATCH_ADDR_W-1:0]   i_addr,
  input  logic [N-1:0]              i_valid,
  input  logic [N*MATCH_ADDR_W-1:0] i_rd,
  input  logic [N*MATCH_DATA_W-1:0] i_wd,
  input  logic                      i_out_valid,
  input  logic [MATCH_ADDR_W-1:0]   i_out_rd,
  input  logic [MATCH_DATA_W-1:0]   i_out_wd,
  output logic                      o_hit,
  output logic [MATCH_DATA_W-1:0]   o_data
);

  // Entry 0 is the oldest (head); later matches override earlier ones so the
  // youngest pending write wins, with the output register lowest of all.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    if (i_out_valid && (i_out_rd == i_addr)) begin
      o_hit  = 1'b1;
      o_data = i_out_wd;
    end
    for (int i = 0; i < N; i++) begin
      if (i_valid[i] && (i_rd[i*MATCH_ADDR_W +: MATCH_ADDR_W] == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_wd[i*MATCH_DATA_W +: MATCH_DATA_W];
      end
    end
  end

endmodule
`endif

// File: rtl/reg_writeback_queue.sv
// In-order write queue feeding the register file write port, with optional
// pending-write forwarding selected by the WBQ_BYPASS_EN macro.
module reg_writeback_queue
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_wd,
  input  logic              rf_grant,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [ADDR_W-1:0] fw_rs,
  input  logic [ADDR_W-1:0] fw_rt,
  output logic              fw_hit_a,
  output logic [DATA_W-1:0] fw_data_a,
  output logic              fw_hit_b,
  output logic [DATA_W-1:0] fw_data_b,
  output logic [ADDR_W:0]   count,
  output logic              idle
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] r_rd_mem [DEPTH];
  logic [DATA_W-1:0] r_wd_mem [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_wd;

  logic w_push;
  logic w_pop;

  // No pop-through: a full queue refuses input even while it is draining.
  assign in_ready = (r_count < FULL_CNT);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && rf_grant;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wp] <= in_rd;
      r_wd_mem[r_wp] <= in_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= w_pop;
      if (w_push) begin
        r_wp <= r_wp + PTR_ONE;
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_ONE;
        r_rd <= r_rd_mem[r_rp];
        r_wd <= r_wd_mem[r_rp];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rf_we = r_we;
  assign rf_rd = r_rd;
  assign rf_wd = r_wd;
  assign count = r_count;
  assign idle  = (r_count == '0) && !r_we;

`ifdef WBQ_BYPASS_EN
  logic [DEPTH-1:0]        w_ent_valid;
  logic [DEPTH*ADDR_W-1:0] w_ent_rd;
  logic [DEPTH*DATA_W-1:0] w_ent_wd;

  // Re-index the ring so slot 0 is the head and the matcher can rank by age.
  always_comb begin
    w_ent_valid = '0;
    w_ent_rd    = '0;
    w_ent_wd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ent_valid[i]                = ((ADDR_W+1)'(i) < r_count);
      w_ent_rd[i*ADDR_W +: ADDR_W]  = r_rd_mem[r_rp + PTR_W'(i)];
      w_ent_wd[i*DATA_W +: DATA_W]  = r_wd_mem[r_rp + PTR_W'(i)];
    end
  end

  wbq_fwd_match #(
    .MATCH_DATA_W(DATA_W),
    .MATCH_ADDR_W(ADDR_W),
    .N           (DEPTH)
  ) u_match_a (
    .i_addr     (fw_rs),
    .i_valid    (w_ent_valid),
    .i_rd       (w_ent_rd),
    .i_wd       (w_ent_wd),
    .i_out_valid(r_we),
    .i_out_rd   (r_rd),
    .i_out_wd   (r_wd),
    .o_hit      (fw_hit_a),
    .o_data     (fw_data_a)
  );

  wbq_fwd_match #(
    .MATCH_DATA_W(DATA_W),
    .MATCH_ADDR_W(ADDR_W),
    .N           (DEPTH)
  ) u_match_b (
    .i_addr     (fw_rt),
    .i_valid    (w_ent_valid),
    .i_rd       (w_ent_rd),
    .i_wd       (w_ent_wd),
    .i_out_valid(r_we),
    .i_out_rd   (r_rd),
    .i_out_wd   (r_wd),
    .o_hit      (fw_hit_b),
    .o_data     (fw_data_b)
  );
`else
  // Without bypass the CPU stalls on !idle, so lookups are ignored.
  logic w_unused_fw;
  assign w_unused_fw = ^{fw_rs, fw_rt};
  assign fw_hit_a    = 1'b0;
  assign fw_data_a   = '0;
  assign fw_hit_b    = 1'b0;
  assign fw_data_b   = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: accepted requests are queued as
// expected writes and a negedge monitor checks every issued register write.
module tb_reg_writeback_queue;
  import cpu_pkg::*;

`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_wd;
  logic              rf_grant;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wd;
  logic [ADDR_W-1:0] fw_rs;
  logic [ADDR_W-1:0] fw_rt;
  logic              fw_hit_a;
  logic [DATA_W-1:0] fw_data_a;
  logic              fw_hit_b;
  logic [DATA_W-1:0] fw_data_b;
  logic [ADDR_W:0]   count;
  logic              idle;

  wb_req_t expQ[$];
  int      mCount      = 0;
  int      vectors     = 0;
  int      miscompares = 0;

  reg_writeback_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_wd    (in_wd),
    .rf_grant (rf_grant),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wd    (rf_wd),
    .fw_rs    (fw_rs),
    .fw_rt    (fw_rt),
    .fw_hit_a (fw_hit_a),
    .fw_data_a(fw_data_a),
    .fw_hit_b (fw_hit_b),
    .fw_data_b(fw_data_b),
    .count    (count),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle from a negedge; the bench's own occupancy model decides
  // acceptance and pop so in_ready, count and rf_we latency are all checked.
  task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] rd,
                               input logic [DATA_W-1:0] wd, input logic g);
    bit      acc;
    bit      pop;
    wb_req_t e;
    in_valid = v;
    in_rd    = rd;
    in_wd    = wd;
    rf_grant = g;
    #1;
    acc = v && (mCount < 4);
    pop = (mCount != 0) && g;
    checkOutput("in_ready", in_ready, (mCount < 4));
    if (acc) begin
      e.rd = rd;
      e.wd = wd;
      expQ.push_back(e);
    end
    mCount = mCount + int'(acc) - int'(pop);
    @(negedge clk);
    checkOutput("count", count, mCount);
    checkOutput("rf_we_latency", rf_we, pop);
  endtask

  task automatic checkFw(input logic hitA, input logic [DATA_W-1:0] dataA,
                         input logic hitB, input logic [DATA_W-1:0] dataB);
    checkOutput("fw_hit_a", fw_hit_a, hitA);
    checkOutput("fw_data_a", fw_data_a, dataA);
    checkOutput("fw_hit_b", fw_hit_b, hitB);
    checkOutput("fw_data_b", fw_data_b, dataB);
  endtask

  // Monitor: every write the DUT presents must match the oldest expected one.
  always @(negedge clk) begin
    wb_req_t e;
    if (rst_n && rf_we) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wb_rd", rf_rd, e.rd);
        checkOutput("wb_wd", rf_wd, e.wd);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_wd    = '0;
    rf_grant = 1'b0;
    fw_rs    = '0;
    fw_rt    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_count", count, 0);
    checkOutput("reset_rf_we", rf_we, 0);
    checkOutput("reset_rf_rd", rf_rd, 0);
    checkOutput("reset_rf_wd", rf_wd, 0);
    checkOutput("reset_idle", idle, 1);
    checkFw(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);

    $display("[TB] single write rd=3 wd=A5");
    applyStimulus(1'b1, 3'd3, 8'hA5, 1'b1);
    checkOutput("t1_idle_busy", idle, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("t1_rf_rd", rf_rd, 3);
    checkOutput("t1_rf_wd", rf_wd, 8'hA5);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    checkOutput("t1_idle_back", idle, 1);

    $display("[TB] fill to full then drain in order");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 3'(i), 8'(8'h11 * i), 1'b0);
    end
    checkOutput("t2_full_count", count, 4);
    checkOutput("t2_full_ready", in_ready, 0);
    applyStimulus(1'b1, 3'd5, 8'h55, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
      checkOutput("t2_drain_rd", rf_rd, i);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    checkOutput("t2_idle", idle, 1);

    $display("[TB] forwarding priority");
    fw_rs = 3'd5;
    fw_rt = 3'd6;
    applyStimulus(1'b1, 3'd5, 8'h10, 1'b0);
    applyStimulus(1'b1, 3'd5, 8'h20, 1'b0);
    #1;
    checkFw(BYP, BYP ? 8'h20 : 8'h00, 1'b0, 8'h00);
    fw_rt = 3'd5;
    #1;
    checkFw(BYP, BYP ? 8'h20 : 8'h00, BYP, BYP ? 8'h20 : 8'h00);
    fw_rt    = 3'd2;
    in_valid = 1'b1;
    in_rd    = 3'd2;
    in_wd    = 8'h77;
    rf_grant = 1'b1;
    #1;
    checkOutput("t3_push_not_visible", fw_hit_b, 0);
    applyStimulus(1'b1, 3'd2, 8'h77, 1'b1);
    checkFw(BYP, BYP ? 8'h20 : 8'h00, BYP, BYP ? 8'h77 : 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkFw(BYP, BYP ? 8'h20 : 8'h00, BYP, BYP ? 8'h77 : 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkFw(1'b0, 8'h00, BYP, BYP ? 8'h77 : 8'h00);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    checkFw(1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("t3_idle", idle, 1);

    $display("[TB] streaming through a full queue");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'(i + 1), 8'(8'h60 + i), 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 3'((i + 5) % 8), 8'(8'h80 + i), 1'b1);
      checkOutput("t4_stream_count", count, 3);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    checkOutput("t4_no_loss", expQ.size(), 0);
    checkOutput("t4_idle", idle, 1);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 3'(7 - i), 8'(8'hC1 + i), 1'b0);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("t5_pre_count", count, 3);
    checkOutput("t5_pre_we", rf_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_we", rf_we, 0);
    checkOutput("t5_rst_rd", rf_rd, 0);
    checkOutput("t5_rst_wd", rf_wd, 0);
    checkOutput("t5_rst_count", count, 0);
    checkOutput("t5_rst_idle", idle, 1);
    expQ.delete();
    mCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    end
    checkOutput("t5_post_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side initiator for the 8x8 register file.
- Accepts register write requests (rd, wd) from execute/memory producers into a small in-order FIFO.
- Drains the FIFO into the register file write port (we/rd/wd), one write per granted cycle.
- Provides youngest-match forwarding so readers see pending data before it commits to the register file.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 3, register index width (2**ADDR_W registers)
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a write request
- in_ready  out  1  queue can accept a request
- in_rd  in  ADDR_W  destination register
- in_wd  in  DATA_W  write data
- rf_grant  in  1  register file write port is free this cycle
- rf_we  out  1  register file write enable (registered)
- rf_rd  out  ADDR_W  register file write address (registered)
- rf_wd  out  DATA_W  register file write data (registered)
- fw_rs  in  ADDR_W  forwarding lookup address A
- fw_rt  in  ADDR_W  forwarding lookup address B
- fw_hit_a  out  1  a pending write to fw_rs exists
- fw_data_a  out  DATA_W  data of the youngest pending write to fw_rs
- fw_hit_b  out  1  a pending write to fw_rt exists
- fw_data_b  out  DATA_W  data of the youngest pending write to fw_rt
- count  out  ADDR_W+1  occupied FIFO entries
- idle  out  1  count==0 and rf_we==0

Behaviour:
- Reset (async, rst_n low):
  - Pointers and count go to 0; rf_we, rf_rd, rf_wd go to 0.
  - Pending entries are discarded; no write is issued after release.
  - Reset mid-operation drops all queued data.
- Push:
  - Occurs on a rising edge when in_valid && in_ready.
  - in_ready = (count < DEPTH), combinational from count only. There is no pop-through: when full, in_ready is 0 even if a pop happens that cycle.
- Pop:
  - Occurs on a rising edge when count != 0 && rf_grant.
  - The head entry loads into rf_rd/rf_wd and rf_we is set to 1.
  - Otherwise rf_we is 0 next cycle; rf_rd/rf_wd hold their last values.
- Simultaneous push and pop: both happen and count is unchanged.
- Order: strictly FIFO. Duplicate rd entries are all issued in order, so the last one wins in the register file.
- Latency:
  - Request accepted at edge N; earliest pop at edge N+1; rf_we high during cycle N+1..N+2.
  - Register file commits at edge N+2.
- Pointers: wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- Forwarding (combinational):
  - Search set = all valid FIFO entries plus the output register while rf_we==1.
  - Priority, youngest first: newest FIFO entry down to the head, then the output register.
  - Miss gives hit=0 and data=0.
  - An entry being pushed in the same cycle is not visible until after the edge.
- idle gives the CPU a drain point, e.g. before halt.

Optional Feature:
- Macro: WBQ_BYPASS_EN.
- Defined: forwarding logic as above.
- Undefined:
  - fw_hit_a/fw_hit_b are tied to 0 and fw_data_a/fw_data_b to 0.
  - fw_rs/fw_rt are unused.
  - The CPU must stall on !idle before reading dependent registers.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=8 and ADDR_W=3 constants;
  - a wb_req_t struct {rd, wd};
  - REG_COUNT=8.
- One sub-module, wbq_fwd_match: a combinational priority match over entries. It takes the valid/rd/wd vectors plus the output register and returns hit/data for one lookup address; it is instantiated twice.

Test Plan:
- Reset then single push of rd=3, wd=0xA5 with rf_grant=1 -> rf_we=1, rf_rd=3, rf_wd=0xA5 one cycle after the pop edge; idle returns to 1 the following cycle.
- rf_grant=0, push 4 entries (rd=1..4, wd=0x11..0x44) -> count=4, in_ready=0, 5th request held. Then grant=1 -> writes issue in order 1,2,3,4 on consecutive cycles.
- Push rd=5/0x10 then rd=5/0x20 with grant=0, fw_rs=5 -> fw_hit_a=1, fw_data_a=0x20. fw_rt=6 -> hit_b=0, data_b=0.
- Full queue with in_valid=1 and grant=1 every cycle -> one push and one pop per cycle after the first pop; count stays stable with no loss. Pointer wrap is checked over 10 or more entries.
- Assert rst_n low asynchronously with count=3 and rf_we=1 -> all outputs 0 immediately, no further rf_we after release, count=0.
- Build with WBQ_BYPASS_EN undefined, repeating the forwarding stimulus -> fw_hit_a=0, fw_data_a=0; queue draining is unchanged.
